// File: rtl/cfg_bus_pkg.sv
// cfg_bus_pkg: shared types for the configuration-bus master.
// Holds the FSM state encoding, the captured-command and response records,
// and the poll-compare helper used when CFG_MASTER_POLL_EN is defined.
package cfg_bus_pkg;

    localparam int unsigned CFG_ADDR_WIDTH = 32;
    localparam int unsigned CFG_DATA_WIDTH = 32;
    localparam int unsigned CFG_BE_WIDTH   = CFG_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Command as captured at acceptance; later cmd_* changes do not reach the bus.
    typedef struct packed {
        logic                      we;
        logic [CFG_ADDR_WIDTH-1:0] addr;
        logic [CFG_BE_WIDTH-1:0]   be;
        logic [CFG_DATA_WIDTH-1:0] wdata;
        logic                      poll;
        logic [CFG_DATA_WIDTH-1:0] mask;
    } cfg_cmd_t;

    typedef struct packed {
        logic [CFG_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } cfg_rsp_t;

    // True when every masked bit of rdata equals the corresponding bit of value.
    function automatic logic poll_match(input logic [CFG_DATA_WIDTH-1:0] rdata,
                                        input logic [CFG_DATA_WIDTH-1:0] value,
                                        input logic [CFG_DATA_WIDTH-1:0] mask);
        return ((rdata ^ value) & mask) == '0;
    endfunction

endpackage

// File: rtl/cfg_bus_master_if.sv
// cfg_bus_master_if: command, response and en/addr/we/be/wdata/rdata bus
// signals of the configuration-bus master. The master modport is the
// initiator's view; the slave modport is the view of whatever sits across it.
// cmd_poll/cmd_mask exist only when CFG_MASTER_POLL_EN is defined.
interface cfg_bus_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    // Command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [BE_WIDTH-1:0]   cmd_be;
    logic [DATA_WIDTH-1:0] cmd_wdata;
`ifdef CFG_MASTER_POLL_EN
    logic                  cmd_poll;
    logic [DATA_WIDTH-1:0] cmd_mask;
`endif

    // Configuration bus
    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    // Response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        input  cmd_valid, output cmd_ready,
        input  cmd_we, cmd_addr, cmd_be, cmd_wdata,
        output en, we, addr, be, wdata,
        input  rdata,
        output rsp_valid, input rsp_ready, output rsp_rdata, rsp_err
`ifdef CFG_MASTER_POLL_EN
        , input cmd_poll, cmd_mask
`endif
    );

    modport slave (
        output cmd_valid, input cmd_ready,
        output cmd_we, cmd_addr, cmd_be, cmd_wdata,
        input  en, we, addr, be, wdata,
        output rdata,
        input  rsp_valid, output rsp_ready, input rsp_rdata, rsp_err
`ifdef CFG_MASTER_POLL_EN
        , output cmd_poll, cmd_mask
`endif
    );

endinterface

// File: rtl/cfg_bus_master.sv
// cfg_bus_master: single-outstanding initiator for the accelerator's
// configuration bus. Accepts one command, checks its address, issues one
// registered en cycle (plus one WAIT cycle for a registered slave), and
// returns one response held until rsp_ready.
// Optional feature: define CFG_MASTER_POLL_EN for masked-compare polling reads.
module cfg_bus_master
    import cfg_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = CFG_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH    = CFG_DATA_WIDTH,
    parameter int unsigned N_CTRL_WORDS  = 4,
    parameter int unsigned N_STAT_WORDS  = 4,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned POLL_MAX_ITER = 256
) (
    input  logic             clk,
    input  logic             arst_n,
    cfg_bus_master_if.master bus
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned N_WORDS  = N_CTRL_WORDS + N_STAT_WORDS;

    state_t                state_q;
    cfg_cmd_t              cmd_q;
    cfg_cmd_t              cmd_d;
    cfg_rsp_t              rsp_q;
    logic                  rsp_valid_q;
    logic                  en_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  cmd_err_d;   // command rejected at acceptance
    logic                  read_done_d; // bus rdata is valid this cycle
    logic                  read_err_d;  // sampled read ends in an error response
    logic                  poll_retry_d;

`ifdef CFG_MASTER_POLL_EN
    localparam int unsigned ITER_WIDTH = $clog2(POLL_MAX_ITER + 1);
    logic [ITER_WIDTH-1:0] iter_q;      // non-matching reads so far
`endif

    // Not every captured field is consumed in every build (be, mask, poll).
    logic unused_cmd_q;
    assign unused_cmd_q = ^cmd_q;

    // Capture record, address check and read-completion decode.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cmd_d        = '0;
        cmd_err_d    = 1'b0;
        read_err_d   = 1'b0;
        poll_retry_d = 1'b0;

        cmd_d.we    = bus.cmd_we;
        cmd_d.addr  = CFG_ADDR_WIDTH'(bus.cmd_addr);
        cmd_d.be    = bus.cmd_we ? CFG_BE_WIDTH'(bus.cmd_be) : '0;
        cmd_d.wdata = CFG_DATA_WIDTH'(bus.cmd_wdata);
`ifdef CFG_MASTER_POLL_EN
        cmd_d.poll  = bus.cmd_poll;
        cmd_d.mask  = CFG_DATA_WIDTH'(bus.cmd_mask);
`endif

        // Status words are read-only, so writes have the smaller legal window.
        if (bus.cmd_we) cmd_err_d = bus.cmd_addr >= ADDR_WIDTH'(N_CTRL_WORDS);
        else            cmd_err_d = bus.cmd_addr >= ADDR_WIDTH'(N_WORDS);
`ifdef CFG_MASTER_POLL_EN
        if (bus.cmd_we && bus.cmd_poll) cmd_err_d = 1'b1;
`endif

        // A combinational slave answers in ISSUE; a registered one in WAIT.
        read_done_d = (state_q == WAIT) ||
                      (state_q == ISSUE && !cmd_q.we && READ_LATENCY == 0);

`ifdef CFG_MASTER_POLL_EN
        if (cmd_q.poll && !poll_match(CFG_DATA_WIDTH'(bus.rdata), cmd_q.wdata, cmd_q.mask)) begin
            poll_retry_d = iter_q != ITER_WIDTH'(POLL_MAX_ITER - 1);
            read_err_d   = !poll_retry_d;
        end
`endif
    end

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
`ifdef CFG_MASTER_POLL_EN
            iter_q      <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            // The bus idles unless a cycle is launched below.
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;

            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_q <= cmd_d;
`ifdef CFG_MASTER_POLL_EN
                        iter_q <= '0;
`endif
                        if (cmd_err_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_q       <= '{rdata: '0, err: 1'b1};
                        end else begin
                            state_q <= ISSUE;
                            en_q    <= 1'b1;
                            we_q    <= cmd_d.we;
                            addr_q  <= ADDR_WIDTH'(cmd_d.addr);
                            be_q    <= BE_WIDTH'(cmd_d.be);
                            wdata_q <= cmd_d.we ? DATA_WIDTH'(cmd_d.wdata) : '0;
                        end
                    end
                end

                ISSUE, WAIT: begin
                    if (cmd_q.we) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_q       <= '0;
                    end else if (!read_done_d) begin
                        state_q <= WAIT;
                    end else if (poll_retry_d) begin
                        // Relaunch the same read the cycle after the sample.
`ifdef CFG_MASTER_POLL_EN
                        iter_q <= iter_q + ITER_WIDTH'(1);
`endif
                        state_q <= ISSUE;
                        en_q    <= 1'b1;
                        addr_q  <= ADDR_WIDTH'(cmd_q.addr);
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_q.rdata <= CFG_DATA_WIDTH'(bus.rdata);
                        rsp_q.err   <= read_err_d;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_q       <= '0;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.en        = en_q;
    assign bus.we        = we_q;
    assign bus.addr      = addr_q;
    assign bus.be        = be_q;
    assign bus.wdata     = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = DATA_WIDTH'(rsp_q.rdata);
    assign bus.rsp_err   = rsp_q.err;

endmodule
